// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
// Segment codes are active low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_UNITS = 2'd1,
    S_TENS  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/display_scan_driver_if.sv
// Value-in / display-out bundle of the scan driver.
// The slave side is the driver itself; the master side is its environment.
interface display_scan_driver_if;
  logic [3:0] value_i;
  logic       value_valid_i;
  logic [6:0] seg_o;
  logic [1:0] an_o;
  logic       tick_o;

  modport master (
    output value_i, value_valid_i,
    input  seg_o, an_o, tick_o
  );

  modport slave (
    input  value_i, value_valid_i,
    output seg_o, an_o, tick_o
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10-15 and an asserted blank flag both give a dark digit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Look up the segment pattern, forcing blank for non-decimal codes
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (digit < 4'd10) begin
      seg = SEG_LUT[digit];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Two-digit multiplexed seven-segment driver: refresh prescaler, units/tens scan,
// frame-aligned value latching and registered active-low segment/anode outputs.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50_000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_driver_if.slave bus
);

  localparam int unsigned    CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_s;
  scan_state_t   state_r, state_next_s;
  logic          frame_s;
  logic [3:0]    pend_r, pend_next_s;
  logic          pend_v_r, pend_v_next_s;
  logic [3:0]    shown_r, shown_next_s;
  logic [3:0]    tens_s, units_s, digit_s;
  logic          blank_s;
  logic [1:0]    an_next_s;
  logic [6:0]    seg_dec_s;
  logic [1:0]    an_r;
  logic [6:0]    seg_r;

  assign tick_s = (cnt_r == CNT_LAST);

  // Slot prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_OFF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scan sequencing; S_OFF only leaves on the first tick and is never revisited
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_OFF:   state_next_s = tick_s ? S_UNITS : S_OFF;
      S_UNITS: state_next_s = tick_s ? S_TENS  : S_UNITS;
      S_TENS:  state_next_s = tick_s ? S_UNITS : S_TENS;
      default: state_next_s = S_UNITS;
    endcase
    frame_s = tick_s && (state_next_s == S_UNITS);
  end

  // Pending/shown value update; a strobe on a frame tick goes straight to shown
  always_comb begin
    shown_next_s  = shown_r;
    pend_next_s   = pend_r;
    pend_v_next_s = pend_v_r;
    if (frame_s) begin
      if (bus.value_valid_i) begin
        shown_next_s  = bus.value_i;
        pend_v_next_s = 1'b0;
      end else if (pend_v_r) begin
        shown_next_s  = pend_r;
        pend_v_next_s = 1'b0;
      end else begin
        shown_next_s  = shown_r;
      end
    end else if (bus.value_valid_i) begin
      pend_next_s   = bus.value_i;
      pend_v_next_s = 1'b1;
    end else begin
      pend_next_s   = pend_r;
    end
  end

  // Value registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r   <= 4'd0;
      pend_v_r <= 1'b0;
      shown_r  <= 4'd0;
    end else begin
      pend_r   <= pend_next_s;
      pend_v_r <= pend_v_next_s;
      shown_r  <= shown_next_s;
    end
  end

  // Digit split and slot selection, evaluated for the state being entered
  always_comb begin
    if (shown_next_s >= 4'd10) begin
      tens_s  = 4'd1;
      units_s = shown_next_s - 4'd10;
    end else begin
      tens_s  = 4'd0;
      units_s = shown_next_s;
    end
    case (state_next_s)
      S_UNITS: begin
        digit_s   = units_s;
        blank_s   = 1'b0;
        an_next_s = AN_UNITS;
      end
      S_TENS: begin
        digit_s   = tens_s;
        blank_s   = BLANK_LZ && (tens_s == 4'd0);
        an_next_s = AN_TENS;
      end
      default: begin
        digit_s   = 4'd0;
        blank_s   = 1'b1;
        an_next_s = AN_OFF;
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .digit (digit_s),
    .blank (blank_s),
    .seg   (seg_dec_s)
  );

  // Output register, updates on the same edge as the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_dec_s;
    end
  end

  assign bus.seg_o  = seg_r;
  assign bus.an_o   = an_r;
  assign bus.tick_o = tick_s;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: two instances (leading-zero blanking on and off)
// driven in lockstep, checked against a fixed vector table and an edge-count model.
module tb_display_scan_driver;

  localparam int R = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  display_scan_driver_if bus1 ();
  display_scan_driver_if bus0 ();

  display_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  display_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: edges since reset release, latched and pending values
  int m_n;
  int m_shown;
  int m_pend;
  bit m_pend_v;

  typedef struct {
    logic       vv;
    logic [3:0] val;
    int         len;
    logic [1:0] an;
    logic [6:0] s1;
    logic [6:0] s0;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 7'h40;
      1: ref_seg = 7'h79;
      2: ref_seg = 7'h24;
      3: ref_seg = 7'h30;
      4: ref_seg = 7'h19;
      5: ref_seg = 7'h12;
      6: ref_seg = 7'h02;
      7: ref_seg = 7'h78;
      8: ref_seg = 7'h00;
      9: ref_seg = 7'h10;
      default: ref_seg = 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_shown  = 0;
    m_pend   = 0;
    m_pend_v = 1'b0;
  endtask

  task automatic model_edge(input bit vv, input int v);
    bit frame;
    m_n++;
    frame = (m_n % R == 0) && ((m_n / R) % 2 == 1);
    if (frame) begin
      if (vv) m_shown = v;
      else if (m_pend_v) m_shown = m_pend;
      if (vv || m_pend_v) m_pend_v = 1'b0;
    end else if (vv) begin
      m_pend   = v;
      m_pend_v = 1'b1;
    end
  endtask

  task automatic model_check();
    logic [1:0] e_an;
    logic [6:0] e_s1;
    logic [6:0] e_s0;
    if (m_n < R) begin
      e_an = 2'b11; e_s1 = 7'h7F; e_s0 = 7'h7F;
    end else if ((m_n / R) % 2 == 1) begin
      e_an = 2'b10;
      e_s1 = ref_seg(m_shown % 10);
      e_s0 = e_s1;
    end else begin
      e_an = 2'b01;
      e_s0 = ref_seg(m_shown / 10);
      e_s1 = (m_shown / 10 == 0) ? 7'h7F : e_s0;
    end
    chk("model_an_blz1", {6'd0, bus1.an_o}, {6'd0, e_an});
    chk("model_an_blz0", {6'd0, bus0.an_o}, {6'd0, e_an});
    chk("model_seg_blz1", {1'b0, bus1.seg_o}, {1'b0, e_s1});
    chk("model_seg_blz0", {1'b0, bus0.seg_o}, {1'b0, e_s0});
    chk("model_tick", {7'd0, bus1.tick_o}, {7'd0, (m_n % R) == R - 1});
  endtask

  // One clock edge with the given strobe presented across it
  task automatic step(input bit vv, input logic [3:0] v);
    bus1.value_valid_i = vv;
    bus0.value_valid_i = vv;
    bus1.value_i       = v;
    bus0.value_i       = v;
    @(posedge clk);
    #1;
    bus1.value_valid_i = 1'b0;
    bus0.value_valid_i = 1'b0;
    model_edge(vv, int'(v));
    model_check();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus1.value_valid_i = 1'b0;
    bus0.value_valid_i = 1'b0;
    bus1.value_i       = 4'd0;
    bus0.value_i       = 4'd0;
    model_reset();

    // Edge-by-edge expectations for R = 4 after reset release
    tbl[0]  = '{1'b0, 4'd0,  3, 2'b11, 7'h7F, 7'h7F};
    tbl[1]  = '{1'b0, 4'd0,  1, 2'b10, 7'h40, 7'h40};
    tbl[2]  = '{1'b1, 4'd13, 3, 2'b10, 7'h40, 7'h40};
    tbl[3]  = '{1'b0, 4'd0,  4, 2'b01, 7'h7F, 7'h40};
    tbl[4]  = '{1'b0, 4'd0,  4, 2'b10, 7'h30, 7'h30};
    tbl[5]  = '{1'b0, 4'd0,  2, 2'b01, 7'h79, 7'h79};
    tbl[6]  = '{1'b1, 4'd7,  2, 2'b01, 7'h79, 7'h79};
    tbl[7]  = '{1'b0, 4'd0,  4, 2'b10, 7'h78, 7'h78};
    tbl[8]  = '{1'b0, 4'd0,  4, 2'b01, 7'h7F, 7'h40};
    tbl[9]  = '{1'b1, 4'd12, 4, 2'b10, 7'h24, 7'h24};
    tbl[10] = '{1'b0, 4'd0,  1, 2'b01, 7'h79, 7'h79};
    tbl[11] = '{1'b1, 4'd5,  2, 2'b01, 7'h79, 7'h79};
    tbl[12] = '{1'b1, 4'd9,  1, 2'b01, 7'h79, 7'h79};
    tbl[13] = '{1'b0, 4'd0,  4, 2'b10, 7'h10, 7'h10};
    tbl[14] = '{1'b0, 4'd0,  1, 2'b01, 7'h7F, 7'h40};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", {6'd0, bus1.an_o}, 8'h03);
    chk("reset_seg", {1'b0, bus1.seg_o}, 8'h7F);
    chk("reset_tick", {7'd0, bus1.tick_o}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < tbl[r].len; k++) begin
        step((k == 0) ? tbl[r].vv : 1'b0, tbl[r].val);
        chk($sformatf("tbl%0d_an", r), {6'd0, bus1.an_o}, {6'd0, tbl[r].an});
        chk($sformatf("tbl%0d_an0", r), {6'd0, bus0.an_o}, {6'd0, tbl[r].an});
        chk($sformatf("tbl%0d_seg_blz1", r), {1'b0, bus1.seg_o}, {1'b0, tbl[r].s1});
        chk($sformatf("tbl%0d_seg_blz0", r), {1'b0, bus0.seg_o}, {1'b0, tbl[r].s0});
      end
    end

    // Random strobes, values and spacing against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-slot, then a clean restart showing 0
    #3;
    chk("pre_reset_active", {7'd0, bus1.an_o != 2'b11}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("async_reset_an1", {6'd0, bus1.an_o}, 8'h03);
    chk("async_reset_an0", {6'd0, bus0.an_o}, 8'h03);
    chk("async_reset_seg1", {1'b0, bus1.seg_o}, 8'h7F);
    chk("async_reset_seg0", {1'b0, bus0.seg_o}, 8'h7F);
    chk("async_reset_tick", {7'd0, bus1.tick_o}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd0);
      if (i == 3) begin
        chk("restart_an", {6'd0, bus1.an_o}, 8'h02);
        chk("restart_seg", {1'b0, bus1.seg_o}, 8'h40);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
